keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter CLK_DIV, default 5000, meaning clocks per scan tick (range 2..2^21-1).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical tick samples needed to accept a press or a release (range 1..15).
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 col_in  input  4  matrix column sense, active-low, pulled up externally, asynchronous to clk.
REQ-006 row_out  output  4  matrix row drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of last accepted key = row_idx*4 + col_idx; feeds game controller keypad_input.
REQ-008 key_valid  output  1  one-clk pulse when a debounced press is accepted; feeds game controller keypad_enable.
REQ-009 key_down  output  1  level, high from accepted press until debounced release.
REQ-010 multi_key  output  1  one-clk pulse when a tick sample shows more than one column low.

Function
REQ-011 col_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-012 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick is high for the single clk in which counter == CLK_DIV-1.
REQ-013 State machine SHALL have states SCAN, DEBOUNCE, PRESSED, RELEASE; all transitions occur only on tick.
REQ-014 row_out SHALL equal ~(1 << row_idx); row_idx (2 bits) changes only in SCAN on tick or when leaving RELEASE/DEBOUNCE to SCAN.
REQ-015 SCAN, tick, col_s == 4'b1111: row_idx increments, wrapping 3 -> 0.
REQ-016 SCAN, tick, exactly one col_s bit low: capture col_idx, set deb_cnt = 1, go DEBOUNCE, row_idx held.
REQ-017 SCAN, tick, two or more col_s bits low: pulse multi_key, no capture, row_idx increments as in REQ-015.
REQ-018 DEBOUNCE, tick, col_s equals the captured single-low pattern: deb_cnt increments; when incremented value reaches DEBOUNCE_SCANS go PRESSED.
REQ-019 DEBOUNCE_SCANS == 1: the SCAN capture tick itself SHALL accept the press (go directly to PRESSED).
REQ-020 DEBOUNCE, tick, col_s differs from captured pattern: return to SCAN, row_idx increments, no output change.
REQ-021 On entry to PRESSED: key_code updated, key_valid high for exactly one clk, key_down set, all in the clk following the accepting tick.
REQ-022 PRESSED, tick, col_s == 4'b1111: deb_cnt = 1, go RELEASE; any other value: stay, no new key_valid.
REQ-023 RELEASE, tick, col_s == 4'b1111: deb_cnt increments; on reaching DEBOUNCE_SCANS clear key_down, go SCAN, row_idx increments.
REQ-024 RELEASE, tick, col_s not all-ones: return to PRESSED with no key_valid (bounce on release).
REQ-025 key_code SHALL hold its value after release until the next accepted press.
REQ-026 A second key pressed in another row while PRESSED SHALL be ignored (row not scanned); a second column in the same row SHALL keep state PRESSED.
REQ-027 deb_cnt SHALL be 4 bits and saturate, never wrap.

Reset
REQ-028 While reset is high: state SCAN, row_idx 0 (row_out 4'b1110), tick counter 0, deb_cnt 0, key_code 4'h0, key_valid 0, key_down 0, multi_key 0, synchronizer flops 4'b1111.
REQ-029 Reset asserted mid-press SHALL abort with no key_valid; after release of reset scanning restarts at row 0 and a still-held key is re-debounced from zero.

Verification (CLK_DIV=4, DEBOUNCE_SCANS=3)
REQ-030 Idle col_in=4'hF for 40 clk -> row_out cycles 1110,1101,1011,0111,1110 changing every 4 clk; key_valid never high.
REQ-031 Hold key row 2 col 1 (col_in=4'b1101 while row_out=4'b1011) -> exactly one key_valid pulse, key_code=4'h9, key_down high, row_out frozen at 1011 until release.
REQ-032 Press row 1 col 3 for only 2 ticks then release -> no key_valid, scanning resumes at row 2.
REQ-033 Hold row 0 col 0, then bounce release (F,F,E,F,F,F on successive ticks) -> key_down stays high through bounce, clears after third consecutive F, single key_valid total, key_code=4'h0 retained.
REQ-034 col_in=4'b1100 during row 3 -> multi_key one-clk pulse, no key_valid, row_out advances to 1110.
REQ-035 Assert reset during DEBOUNCE of row 3 col 2 -> all outputs at REQ-028 values; key still held after reset -> key_valid after 3 matching ticks on row 3 with key_code=4'hE.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces a single
// pressed key over several scan ticks and reports its code with a one-clk strobe.
module keypad_scanner #(
    parameter int CLK_DIV        = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_key
);
    localparam logic [20:0] TICK_MAX = 21'(CLK_DIV - 1);
    localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [20:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [3:0]  row_out_q, row_out_d;
    logic [3:0]  col_pat_q, col_pat_d;
    logic [3:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_down_q, key_down_d;
    logic        multi_key_q, multi_key_d;

    logic        tick, all_high, one_low, accept, release_key;
    logic [1:0]  col_idx;
    logic [3:0]  deb_inc, col_s;

    always_comb begin
        col_s    = sync2_q;
        tick     = (cnt_q == TICK_MAX);
        all_high = (col_s == 4'hF);
        one_low  = ($countones(~col_s) == 1);
        deb_inc  = (deb_cnt_q == 4'hF) ? 4'hF : deb_cnt_q + 4'd1;
        case (col_s)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        sync1_d     = col_in;
        sync2_d     = sync1_q;
        cnt_d       = tick ? '0 : cnt_q + 21'd1;
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_pat_d   = col_pat_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        key_valid_d = 1'b0;
        multi_key_d = 1'b0;
        accept      = 1'b0;
        release_key = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (all_high) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else if (one_low) begin
                        col_pat_d = col_s;
                        deb_cnt_d = 4'd1;
                        if (DEB_MAX <= 4'd1) accept = 1'b1;
                        else                 state_d = DEBOUNCE;
                    end else begin
                        multi_key_d = 1'b1;
                        row_idx_d   = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == col_pat_q) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc >= DEB_MAX) accept = 1'b1;
                    end else begin
                        state_d   = SCAN;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    // Extra columns in the held row are tolerated; only all-high starts a release.
                    if (all_high) begin
                        deb_cnt_d = 4'd1;
                        if (DEB_MAX <= 4'd1) release_key = 1'b1;
                        else                 state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc >= DEB_MAX) release_key = 1'b1;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            state_d     = PRESSED;
            key_code_d  = {row_idx_q, col_idx};
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
        end
        if (release_key) begin
            state_d    = SCAN;
            key_down_d = 1'b0;
            row_idx_d  = row_idx_q + 2'd1;
        end
        row_out_d = ~(4'b0001 << row_idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            cnt_q       <= '0;
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            row_out_q   <= 4'b1110;
            col_pat_q   <= 4'hF;
            deb_cnt_q   <= 4'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            row_out_q   <= row_out_d;
            col_pat_q   <= col_pat_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 matrix model drives col_in, a tick-level
// behavioural model predicts every output each cycle, and directed scenarios pin key values.
module tb_keypad_scanner;
    localparam int CLK_DIV = 4;
    localparam int DS      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out, key_code;
    logic       key_valid, key_down, multi_key;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to its row while that row is driven low.
    logic [3:0] keys [4];
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_val = 4'hF;
    logic [3:0] col_phys;
    always_comb begin
        col_phys = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && keys[r][c]) col_phys[c] = 1'b0;
        col_in = ovr_en ? ovr_val : col_phys;
    end

    int checks = 0, errors = 0, valid_cnt = 0, multi_cnt = 0;
    logic [3:0] row_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, advanced once per clock edge.
    int         m_cnt = 0, m_row = 0, m_pst = 0, m_rst = 0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_pat = 4'hF, m_code = 4'h0;
    bit         m_cand = 0, m_held = 0;
    logic       m_valid = 0, m_multi = 0, m_down = 0;

    task automatic model_step();
        logic [3:0] cs;
        int lows, ci;
        bit acc, rel;
        if (reset) begin
            m_cnt = 0; m_row = 0; m_pst = 0; m_rst = 0; m_s1 = 4'hF; m_s2 = 4'hF;
            m_pat = 4'hF; m_code = 4'h0; m_cand = 0; m_held = 0;
            m_valid = 0; m_multi = 0; m_down = 0;
            return;
        end
        cs = m_s2; acc = 0; rel = 0; m_valid = 0; m_multi = 0;
        if (m_cnt == CLK_DIV - 1) begin
            lows = 0;
            for (int i = 0; i < 4; i++) if (!cs[i]) lows++;
            if (m_held) begin
                if (cs == 4'hF) begin m_rst++; if (m_rst >= DS) rel = 1; end
                else m_rst = 0;
            end else if (m_cand) begin
                if (cs == m_pat) begin m_pst++; if (m_pst >= DS) acc = 1; end
                else begin m_cand = 0; m_row = (m_row + 1) % 4; end
            end else begin
                if (lows == 0) m_row = (m_row + 1) % 4;
                else if (lows == 1) begin
                    m_pat = cs; m_pst = 1; m_cand = 1;
                    if (m_pst >= DS) acc = 1;
                end else begin
                    m_multi = 1; m_row = (m_row + 1) % 4;
                end
            end
            if (acc) begin
                ci = 0;
                for (int i = 0; i < 4; i++) if (!m_pat[i]) ci = i;
                m_code = 4'(m_row * 4 + ci);
                m_valid = 1; m_down = 1; m_held = 1; m_cand = 0; m_rst = 0;
            end
            if (rel) begin
                m_held = 0; m_rst = 0; m_down = 0; m_row = (m_row + 1) % 4;
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        m_s2 = m_s1;
        m_s1 = col_in;
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        cmp("row_out", row_out, row_tab[m_row]);
        cmp("row_onehot", 32'($countones(~row_out)), 1);
        cmp("key_valid", key_valid, m_valid);
        cmp("key_down", key_down, m_down);
        cmp("key_code", key_code, m_code);
        cmp("multi_key", multi_key, m_multi);
        if (key_valid === 1'b1) valid_cnt++;
        if (multi_key === 1'b1) multi_cnt++;
    end

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (key_valid !== 1'b1 && n < budget);
        if (key_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_valid: key_valid not seen within %0d clk", budget);
        end
    endtask

    task automatic wait_down_low(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (key_down !== 1'b0 && n < budget);
        if (key_down !== 1'b0) begin
            checks++; errors++;
            $display("FAIL wait_release: key_down still high after %0d clk", budget);
        end
    endtask

    task automatic wait_row(input logic [3:0] val);
        int n = 0;
        while (row_out === val && n < 100) begin @(negedge clk); n++; end
        while (row_out !== val && n < 100) begin @(negedge clk); n++; end
        if (row_out !== val) begin
            checks++; errors++;
            $display("FAIL wait_row: row_out %0h never reached %0h", row_out, val);
        end
    endtask

    logic [3:0] bvals [6] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};

    initial begin
        int n, v0, m0;
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp("rst_row_out", row_out, 4'hE);
        cmp("rst_key_code", key_code, 4'h0);
        cmp("rst_key_valid", key_valid, 1'b0);
        cmp("rst_key_down", key_down, 1'b0);
        cmp("rst_multi_key", multi_key, 1'b0);
        reset = 1'b0;
        $display("idle scan, 40 clk");
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k % 4 == 2 && k <= 18) cmp("idle_row_seq", row_out, row_tab[(k / 4) % 4]);
        end
        cmp("idle_no_valid", valid_cnt, 0);

        $display("hold row 2 col 1");
        @(negedge clk); keys[2] = 4'b0010;
        wait_valid(100, n);
        cmp("r2c1_code", key_code, 4'h9);
        cmp("r2c1_down", key_down, 1'b1);
        repeat (30) @(negedge clk);
        cmp("r2c1_row_frozen", row_out, 4'hB);
        cmp("r2c1_single_valid", valid_cnt, 1);
        keys[2] = 4'h0;
        wait_down_low(100);

        $display("short press row 1 col 3");
        v0 = valid_cnt;
        wait_row(4'hD);
        keys[1] = 4'b1000;
        repeat (8) @(negedge clk);
        keys[1] = 4'h0;
        repeat (5) @(negedge clk);
        cmp("short_row_resume", row_out, 4'hB);
        cmp("short_no_valid", valid_cnt, v0);
        cmp("short_no_down", key_down, 1'b0);

        $display("row 0 col 0 with release bounce");
        v0 = valid_cnt;
        @(negedge clk); keys[0] = 4'b0001;
        wait_valid(100, n);
        ovr_en = 1'b1;
        keys[0] = 4'h0;
        for (int k = 0; k < 6; k++) begin
            ovr_val = bvals[k];
            repeat (4) @(negedge clk);
            if (k == 4) cmp("bounce_down_held", key_down, 1'b1);
            if (k == 5) cmp("bounce_down_clear", key_down, 1'b0);
        end
        ovr_en = 1'b0;
        cmp("bounce_code_kept", key_code, 4'h0);
        cmp("bounce_single_valid", valid_cnt, v0 + 1);

        $display("two columns low on row 3");
        v0 = valid_cnt; m0 = multi_cnt;
        wait_row(4'h7);
        keys[3] = 4'b0011;
        repeat (4) @(negedge clk);
        keys[3] = 4'h0;
        cmp("multi_pulse", multi_cnt, m0 + 1);
        cmp("multi_row_next", row_out, 4'hE);
        cmp("multi_no_valid", valid_cnt, v0);

        $display("reset during debounce of row 3 col 2");
        wait_row(4'h7);
        keys[3] = 4'b0100;
        repeat (5) @(negedge clk);
        v0 = valid_cnt;
        reset = 1'b1;
        #1;
        cmp("abort_row_out", row_out, 4'hE);
        cmp("abort_valid", key_valid, 1'b0);
        cmp("abort_down", key_down, 1'b0);
        cmp("abort_code", key_code, 4'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_valid(60, n);
        cmp("redebounce_latency", n, 24);
        cmp("redebounce_code", key_code, 4'hE);
        cmp("redebounce_count", valid_cnt, v0 + 1);
        keys[3] = 4'h0;
        wait_down_low(100);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
